mac_seq_ctrl: RTL

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for a MAC array: loads K, streams K operand beats, drains, returns the result.
// Optional perf counters (perf_jobs, perf_bubbles) enabled by defining MAC_SEQ_CTRL_PERF_EN.
module mac_seq_ctrl #(
  parameter int MULER_WIDTH  = 8,
  parameter int NUM_WIDTH    = 12,
  parameter int OUTPUT_WIDTH = 32,
  parameter int ROW_SIZE     = 8,
  parameter int COLUMN_SIZE  = 8,
  parameter int DRAIN_CYCLES = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [NUM_WIDTH-1:0]             job_k,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [ROW_SIZE*MULER_WIDTH-1:0]  op_a,
  input  logic [COLUMN_SIZE*MULER_WIDTH-1:0] op_b,
  output logic                             mac_num_valid,
  output logic [NUM_WIDTH-1:0]             mac_num,
  output logic [ROW_SIZE*MULER_WIDTH-1:0]  mac_data_a,
  output logic [COLUMN_SIZE*MULER_WIDTH-1:0] mac_data_b,
  input  logic [ROW_SIZE*OUTPUT_WIDTH-1:0] mac_result,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [ROW_SIZE*OUTPUT_WIDTH-1:0] res_data,
  output logic                             res_underrun,
  output logic                             busy
`ifdef MAC_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]                      perf_jobs,
  output logic [31:0]                      perf_bubbles
`endif
);

  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int CNT_W = (NUM_WIDTH > DRN_W) ? NUM_WIDTH : DRN_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_OUT} state_t;

  state_t                          r_state, w_next;
  logic [NUM_WIDTH-1:0]            r_k;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_underrun;
  logic                            r_res_valid;
  logic                            r_res_underrun;
  logic [ROW_SIZE*OUTPUT_WIDTH-1:0] r_res_data;
  logic [CNT_W-1:0]                w_k_ext;
  logic                            w_feed_last;
  logic                            w_drain_last;

  assign w_k_ext      = CNT_W'(r_k);
  assign w_feed_last  = (r_cnt == w_k_ext - CNT_W'(1));
  assign w_drain_last = (r_cnt == CNT_W'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    job_ready     = 1'b0;
    op_ready      = 1'b0;
    mac_num_valid = 1'b0;
    mac_num       = '0;
    mac_data_a    = '0;
    mac_data_b    = '0;
    case (r_state)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        mac_num_valid = 1'b1;
        mac_num       = r_k;
        w_next        = (r_k != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        // A missing beat still consumes its slot; the array sees zeros instead.
        op_ready = 1'b1;
        if (op_valid) begin
          mac_data_a = op_a;
          mac_data_b = op_b;
        end
        if (w_feed_last) w_next = S_DRAIN;
      end
      S_DRAIN: if (w_drain_last) w_next = S_OUT;
      S_OUT:   if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      job_ready     = 1'b0;
      op_ready      = 1'b0;
      mac_num_valid = 1'b0;
      mac_num       = '0;
      mac_data_a    = '0;
      mac_data_b    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k            <= '0;
      r_cnt          <= '0;
      r_underrun     <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_underrun <= 1'b0;
      r_res_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (job_valid) r_k <= job_k;
        S_LOAD: r_cnt <= '0;
        S_FEED: begin
          if (!op_valid) r_underrun <= 1'b1;
          r_cnt <= w_feed_last ? '0 : r_cnt + CNT_W'(1);
        end
        S_DRAIN: begin
          r_cnt <= w_drain_last ? '0 : r_cnt + CNT_W'(1);
          if (w_drain_last) begin
            r_res_data     <= mac_result;
            r_res_underrun <= r_underrun;
            r_res_valid    <= 1'b1;
          end
        end
        S_OUT: if (res_ready) begin
          r_res_valid    <= 1'b0;
          r_res_underrun <= 1'b0;
          r_underrun     <= 1'b0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE) && !rst;
  assign res_valid    = r_res_valid && !rst;
  assign res_underrun = r_res_underrun && !rst;
  assign res_data     = rst ? '0 : r_res_data;

`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [31:0] r_perf_jobs, r_perf_bubbles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_jobs    <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (r_state == S_OUT && res_ready)  r_perf_jobs    <= r_perf_jobs + 32'd1;
      if (r_state == S_FEED && !op_valid) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_jobs    = r_perf_jobs;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
